// File: rtl/wave_pkg.sv
// Shared definitions for the waveform BRAM writer and the BRAM-reading controller:
// load states and the word layout of the waveform image in BRAM.
package wave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_DIV = 3'd1,
    ST_HDR_CNT = 3'd2,
    ST_SAMPLES = 3'd3,
    ST_CHK     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } wave_state_t;

  localparam logic [31:0] WORD_BYTES  = 32'd4;
  localparam logic [31:0] HDR_DIV_OFS = 32'd0;
  localparam logic [31:0] HDR_CNT_OFS = 32'd4;
  localparam logic [31:0] SAMPLE_OFS  = 32'd8;

  // Byte offset of sample k relative to word 0 of the image.
  function automatic logic [31:0] sample_ofs(input logic [31:0] k);
    return SAMPLE_OFS + (k * WORD_BYTES);
  endfunction

endpackage

// File: rtl/wave_wr_addr_gen.sv
// Address and sample counters for the waveform writer: a byte-offset counter that
// advances one word per BRAM write, and a down-counter of samples still to come.
module wave_wr_addr_gen
  import wave_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        wr_xfer,
  input  logic        load_cnt,
  input  logic [31:0] cnt_in,
  input  logic        smp_xfer,
  output logic [31:0] wr_ofs,
  output logic        last_smp
);

  logic [31:0] ofs_q;
  logic [31:0] remain_q;

  // Header and sample words are contiguous, so one running offset covers all of them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ofs_q    <= 32'd0;
      remain_q <= 32'd0;
    end else if (clear) begin
      ofs_q    <= HDR_DIV_OFS;
      remain_q <= 32'd0;
    end else begin
      if (wr_xfer) ofs_q <= ofs_q + WORD_BYTES;
      if (load_cnt) remain_q <= cnt_in;
      else if (smp_xfer) remain_q <= remain_q - 32'd1;
    end
  end

  assign wr_ofs   = ofs_q;
  assign last_smp = (remain_q == 32'd1);

endmodule

// File: rtl/wave_bram_writer.sv
// Loads a streamed waveform image (divisor, count, samples) into BRAM and releases the
// reading controller once done. Optional trailing checksum word: WAVE_WR_CHECKSUM_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start
// HDR_DIV    | accept frequency divisor word, write to word 0
// HDR_CNT    | accept sample count N, write to word 1, range-check N
// SAMPLES    | accept and write N sample words
// CHK        | accept checksum word (not written), compare with running sum
// DONE       | image loaded, controller released from reset
// ERROR      | overflow or checksum error, flags held until next start
module wave_bram_writer #(
  parameter int unsigned MAX_SAMPLES = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wrdata,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic        ctrl_rstn,
  output logic        load_done,
  output logic        err_overflow,
  output logic        err_checksum
);
  import wave_pkg::*;

  localparam logic [31:0] MAX_CNT = 32'(MAX_SAMPLES);
`ifdef WAVE_WR_CHECKSUM_EN
  localparam wave_state_t LOAD_END = ST_CHK;
`else
  localparam wave_state_t LOAD_END = ST_DONE;
`endif

  wave_state_t state_q, state_d;
  logic        xfer, wr_xfer, smp_xfer, load_cnt, clear, set_ovf;
  logic        last_smp, done_q;
  logic [31:0] wr_ofs;

`ifdef WAVE_WR_CHECKSUM_EN
  logic [31:0] csum_q;
  logic        set_csum;
  logic        err_checksum_q;
`endif

  assign s_ready = (state_q == ST_HDR_DIV) || (state_q == ST_HDR_CNT) ||
                   (state_q == ST_SAMPLES) || (state_q == ST_CHK);
  assign xfer    = s_ready && s_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    set_ovf  = 1'b0;
    wr_xfer  = 1'b0;
    smp_xfer = 1'b0;
    load_cnt = 1'b0;
`ifdef WAVE_WR_CHECKSUM_EN
    set_csum = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_HDR_DIV;
        end
      end
      ST_HDR_DIV: begin
        if (xfer) begin
          wr_xfer = 1'b1;
          state_d = ST_HDR_CNT;
        end
      end
      ST_HDR_CNT: begin
        if (xfer) begin
          wr_xfer  = 1'b1;
          load_cnt = 1'b1;
          if (s_data > MAX_CNT) begin
            set_ovf = 1'b1;
            state_d = ST_ERROR;
          end else if (s_data == 32'd0) begin
            state_d = LOAD_END;
          end else begin
            state_d = ST_SAMPLES;
          end
        end
      end
      ST_SAMPLES: begin
        if (xfer) begin
          wr_xfer  = 1'b1;
          smp_xfer = 1'b1;
          if (last_smp) state_d = LOAD_END;
        end
      end
`ifdef WAVE_WR_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          if (s_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            set_csum = 1'b1;
            state_d  = ST_ERROR;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  wave_wr_addr_gen u_addr_gen (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .wr_xfer  (wr_xfer),
    .load_cnt (load_cnt),
    .cnt_in   (s_data),
    .smp_xfer (smp_xfer),
    .wr_ofs   (wr_ofs),
    .last_smp (last_smp)
  );

  // Address and data hold their last value between writes; only en/we pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bram_en     <= 1'b0;
      bram_we     <= 4'h0;
      bram_addr   <= BASE_ADDR;
      bram_wrdata <= 32'd0;
    end else begin
      bram_en <= wr_xfer;
      bram_we <= wr_xfer ? 4'hF : 4'h0;
      if (wr_xfer) begin
        bram_addr   <= BASE_ADDR + wr_ofs;
        bram_wrdata <= s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_overflow <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (clear)        err_overflow <= 1'b0;
      else if (set_ovf) err_overflow <= 1'b1;
    end
  end

  // The final write lands the cycle after DONE is entered; done_q delays the release
  // by that cycle, while leaving DONE drops it at once.
  assign ctrl_rstn = (state_q == ST_DONE) && done_q;
  assign load_done = (state_q == ST_DONE);

`ifdef WAVE_WR_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csum_q         <= 32'd0;
      err_checksum_q <= 1'b0;
    end else begin
      if (clear)        csum_q <= 32'd0;
      else if (wr_xfer) csum_q <= csum_q + s_data;
      if (clear)         err_checksum_q <= 1'b0;
      else if (set_csum) err_checksum_q <= 1'b1;
    end
  end
  assign err_checksum = err_checksum_q;
`else
  assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_wave_bram_writer.sv
// Directed bench for wave_bram_writer: logs every BRAM write and checks contents,
// ordering, flags and controller release against hand-derived values.
module tb_wave_bram_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic        ctrl_rstn;
  logic        load_done;
  logic        err_overflow;
  logic        err_checksum;

  int n_chk = 0;
  int n_fail = 0;

  // Monitor-owned state
  logic [31:0] wlog_a [0:1023];
  logic [31:0] wlog_d [0:1023];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          rise_cyc = 0;
  int          bad_we = 0;
  logic        ctrl_prev = 1'b0;

  wave_bram_writer #(.MAX_SAMPLES(4096), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .bram_addr    (bram_addr),
    .bram_wrdata  (bram_wrdata),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .ctrl_rstn    (ctrl_rstn),
    .load_done    (load_done),
    .err_overflow (err_overflow),
    .err_checksum (err_checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bram_en) begin
      if (wr_cnt < 1024) begin
        wlog_a[wr_cnt] = bram_addr;
        wlog_d[wr_cnt] = bram_wrdata;
      end
      wr_cnt = wr_cnt + 1;
      last_wr_cyc = cyc;
      if (bram_we !== 4'hF) bad_we = bad_we + 1;
    end else if (bram_we !== 4'h0) begin
      bad_we = bad_we + 1;
    end
    if (ctrl_rstn && !ctrl_prev) rise_cyc = cyc;
    ctrl_prev = ctrl_rstn;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] smp(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input bit gap);
    int t;
    t = 0;
    if (gap) begin
      @(negedge clk); s_valid = 1'b0; s_data = 32'hDEAD_BEEF;
    end
    @(negedge clk); s_data = d; s_valid = 1'b1;
    while (!s_ready && t < 20) begin
      @(negedge clk); t++;
    end
    if (!s_ready) chk("push_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Streams header, n samples and (when enabled) the correct checksum.
  task automatic run_load(input logic [31:0] n, input bit gap);
    logic [31:0] sum;
    pulse_start();
    push(32'h4E2, gap);
    push(n, gap);
    sum = 32'h4E2 + n;
    for (int i = 0; i < int'(n); i++) begin
      push(smp(i), gap);
      sum = sum + smp(i);
    end
`ifdef WAVE_WR_CHECKSUM_EN
    push(sum, gap);
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic check_log(input string tag, input int base, input int n);
    int bad;
    logic [31:0] ea, ed;
    bad = 0;
    for (int j = 0; j < n + 2; j++) begin
      ea = 32'(j) * 32'd4;
      ed = (j == 0) ? 32'h4E2 : (j == 1) ? 32'(n) : smp(j - 2);
      if ((base + j) >= 1024 || wlog_a[base + j] !== ea || wlog_d[base + j] !== ed) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int base;

    // Reset values
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    chk("rst_bram_addr", bram_addr, 32'h0);
    chk("rst_bram_wrdata", bram_wrdata, 32'h0);
    chk("rst_ctrl_rstn", 32'(ctrl_rstn), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_err_checksum", 32'(err_checksum), 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Valid data in IDLE is not consumed
    s_data = 32'h1234_5678; s_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ready", 32'(s_ready), 32'd0);
    chk("idle_no_write", 32'(wr_cnt), 32'd0);
    s_valid = 1'b0;

    // 100 samples, continuous valid
    base = wr_cnt;
    run_load(32'd100, 1'b0);
    chk("cont_wr_cnt", 32'(wr_cnt - base), 32'd102);
    check_log("cont_contents", base, 100);
    chk("cont_last_addr", wlog_a[base + 101], 32'h194);
    chk("cont_load_done", 32'(load_done), 32'd1);
    chk("cont_ctrl_rstn", 32'(ctrl_rstn), 32'd1);
    chk("cont_s_ready", 32'(s_ready), 32'd0);
`ifndef WAVE_WR_CHECKSUM_EN
    chk("cont_ctrl_delay", 32'(rise_cyc - last_wr_cyc), 32'd1);
`endif

    // Same load with a gap before every word; restart from DONE
    base = wr_cnt;
    pulse_start();
    chk("restart_ctrl_rstn", 32'(ctrl_rstn), 32'd0);
    chk("restart_load_done", 32'(load_done), 32'd0);
    chk("restart_s_ready", 32'(s_ready), 32'd1);
    rstn = 1'b0; #1; rstn = 1'b1;
    base = wr_cnt;
    run_load(32'd100, 1'b1);
    chk("gap_wr_cnt", 32'(wr_cnt - base), 32'd102);
    check_log("gap_contents", base, 100);
    chk("gap_load_done", 32'(load_done), 32'd1);

    // Sample count above MAX_SAMPLES
    base = wr_cnt;
    pulse_start();
    push(32'h4E2, 1'b0);
    push(32'h1001, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovf_wr_cnt", 32'(wr_cnt - base), 32'd2);
    chk("ovf_cnt_word", wlog_d[base + 1], 32'h1001);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_load_done", 32'(load_done), 32'd0);
    chk("ovf_ctrl_rstn", 32'(ctrl_rstn), 32'd0);
    chk("ovf_s_ready", 32'(s_ready), 32'd0);

    // Restart from ERROR clears the flag; zero-sample image
    base = wr_cnt;
    pulse_start();
    chk("zero_flag_clr", 32'(err_overflow), 32'd0);
    push(32'h4E2, 1'b0);
    push(32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("zero_wr_cnt", 32'(wr_cnt - base), 32'd2);
`ifdef WAVE_WR_CHECKSUM_EN
    chk("zero_in_chk", 32'(s_ready), 32'd1);
    chk("zero_not_done", 32'(load_done), 32'd0);
    push(32'h4E2, 1'b0);
    repeat (2) @(negedge clk);
    chk("zero_chk_wr_cnt", 32'(wr_cnt - base), 32'd2);
`endif
    chk("zero_load_done", 32'(load_done), 32'd1);

    // Reset during sample 50
    pulse_start();
    push(32'h4E2, 1'b0);
    push(32'd100, 1'b0);
    for (int i = 0; i < 50; i++) push(smp(i), 1'b0);
    @(negedge clk);
    s_data = smp(50); s_valid = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_bram_en", 32'(bram_en), 32'd0);
    chk("midrst_bram_we", 32'(bram_we), 32'd0);
    chk("midrst_bram_addr", bram_addr, 32'h0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_ctrl_rstn", 32'(ctrl_rstn), 32'd0);
    base = wr_cnt;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_writes", 32'(wr_cnt - base), 32'd0);
    chk("midrst_idle_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;

    base = wr_cnt;
    run_load(32'd4, 1'b0);
    chk("reload_wr_cnt", 32'(wr_cnt - base), 32'd6);
    check_log("reload_contents", base, 4);
    chk("reload_load_done", 32'(load_done), 32'd1);

`ifdef WAVE_WR_CHECKSUM_EN
    // Explicit checksum vectors
    pulse_start();
    push(32'h4E2, 1'b0); push(32'h2, 1'b0); push(32'h1, 1'b0); push(32'h2, 1'b0);
    push(32'h4E7, 1'b0);
    repeat (2) @(negedge clk);
    chk("csum_ok_done", 32'(load_done), 32'd1);
    chk("csum_ok_flag", 32'(err_checksum), 32'd0);
    pulse_start();
    push(32'h4E2, 1'b0); push(32'h2, 1'b0); push(32'h1, 1'b0); push(32'h2, 1'b0);
    push(32'h4E8, 1'b0);
    repeat (2) @(negedge clk);
    chk("csum_bad_flag", 32'(err_checksum), 32'd1);
    chk("csum_bad_done", 32'(load_done), 32'd0);
    chk("csum_bad_ctrl", 32'(ctrl_rstn), 32'd0);
`endif

    chk("we_encoding", 32'(bad_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
